// File: rtl/seq_player_if.sv
// Handshake and data bundle between the game controller/decoder side and seq_player.
// The master side drives requests and decoder data; the slave side is the player.
interface seq_player_if;
    logic       start;
    logic [3:0] nivel;
    logic [3:0] address;
    logic [3:0] saida;
    logic [3:0] leds;
    logic       busy;
    logic       done;

    modport master (
        output start, nivel, saida,
        input  address, leds, busy, done
    );

    modport slave (
        input  start, nivel, saida,
        output address, leds, busy, done
    );
endinterface

// File: rtl/seq_player.sv
// Plays the Genius color sequence: walks decoder address 0..nivel, flashing each
// returned color for T_ON cycles followed by T_OFF blank cycles, then pulses done.
module seq_player #(
    parameter int unsigned T_ON  = 25000000,
    parameter int unsigned T_OFF = 12500000,
    parameter int unsigned CNT_W = 26
) (
    input  logic        clk,
    input  logic        reset,
    seq_player_if.slave sp
);
    localparam int unsigned LVL_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ON,
        S_OFF,
        S_FIM
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [LVL_W-1:0]   address_q, address_d;
    logic [LVL_W-1:0]   ultimo_q, ultimo_d;
    logic [LVL_W-1:0]   leds_q, leds_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               on_end_c;
    logic               off_end_c;
    logic               last_c;

    assign on_end_c  = (timer_q == CNT_W'(T_ON - 1));
    assign off_end_c = (timer_q == CNT_W'(T_OFF - 1));
    assign last_c    = (address_q == ultimo_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            address_q <= '0;
            ultimo_q  <= '0;
            leds_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            address_q <= address_d;
            ultimo_q  <= ultimo_d;
            leds_q    <= leds_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (sp.start) state_d = S_LOAD;
            S_LOAD: state_d = S_ON;
            S_ON:   if (on_end_c) state_d = S_OFF;
            S_OFF:  if (off_end_c) state_d = last_c ? S_FIM : S_LOAD;
            S_FIM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; done is only ever set on entry to FIM
    always_comb begin
        timer_d   = timer_q;
        address_d = address_q;
        ultimo_d  = ultimo_q;
        leds_d    = leds_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                leds_d = '0;
                if (sp.start) begin
                    ultimo_d  = sp.nivel;
                    address_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_LOAD: begin
                leds_d  = sp.saida;
                timer_d = '0;
            end
            S_ON: begin
                if (on_end_c) begin
                    leds_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_OFF: begin
                leds_d = '0;
                if (off_end_c) begin
                    timer_d = '0;
                    if (last_c) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        address_d = address_q + LVL_W'(1);
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_FIM: begin
                address_d = '0;
                busy_d    = 1'b0;
            end
            default: begin
                leds_d = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign sp.address = address_q;
    assign sp.leds    = leds_q;
    assign sp.busy    = busy_q;
    assign sp.done    = done_q;
endmodule
